// File: rtl/bcd_scan_ctrl.sv
// bcd_scan_ctrl: scans NUM_DIGITS BCD digits through a single BCD-to-decimal
// decoder. Each digit gets a blanking gap, then a dwell with its strobe on.
// New digits land in a shadow buffer and are copied to the active buffer only
// at frame boundaries, so a frame never mixes old and new digits.
module bcd_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_enable,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  output logic                    o_ready,
  output logic                    o_a,
  output logic                    o_b,
  output logic                    o_c,
  output logic                    o_d,
  output logic                    o_cs,
  output logic                    o_n_cs_0,
  output logic                    o_n_cs_1,
  output logic [NUM_DIGITS-1:0]   o_digit_sel,
  output logic                    o_frame_done,
  output logic                    o_bcd_err
);

  localparam int MAXC = (BLANK_CYCLES > DWELL_CYCLES) ? BLANK_CYCLES : DWELL_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW   = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [IW-1:0] IDX_ONE    = IW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  // Digit k of a packed digit vector (mux built from equality compares).
  function automatic logic [3:0] digit_at(input logic [DW-1:0] v, input logic [IW-1:0] k);
    logic [3:0] d;
    d = 4'd0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      d = (k == IW'(j)) ? v[4*j +: 4] : d;
    end
    return d;
  endfunction

  // True when any digit of a packed digit vector is outside 0..9.
  function automatic logic any_invalid(input logic [DW-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      bad = bad | (v[4*j +: 4] > 4'd9);
    end
    return bad;
  endfunction

  state_t          state_r, state_s;
  logic [IW-1:0]   idx_r, idx_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [DW-1:0]   shadow_r, shadow_s;
  logic [DW-1:0]   active_r, active_s;
  logic            pending_r, pending_s;
  logic            bcd_err_r, bcd_err_s;
  logic            frame_done_r, frame_done_s;
  logic            transfer_s;
  logic            ready_r;
  logic [3:0]      abcd_r, abcd_s;
  logic            cs_r, cs_s;
  logic            n_cs_r;
  logic [NUM_DIGITS-1:0] sel_r, sel_s;
  logic [3:0]      cur_digit_s;

  // Next-state, buffer handshake and next-output decode.
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    cnt_s        = cnt_r;
    shadow_s     = shadow_r;
    active_s     = active_r;
    pending_s    = pending_r;
    bcd_err_s    = bcd_err_r;
    frame_done_s = 1'b0;
    transfer_s   = 1'b0;

    case (state_r)
      ST_IDLE: begin
        transfer_s = pending_r;
        if (i_enable) begin
          state_s = ST_BLANK;
          idx_s   = '0;
          cnt_s   = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BLANK: begin
        if (cnt_r == BLANK_LAST) begin
          state_s = ST_SHOW;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_SHOW: begin
        if (cnt_r == DWELL_LAST) begin
          cnt_s = '0;
          if (idx_r == IDX_LAST) begin
            frame_done_s = 1'b1;
            idx_s        = '0;
            if (i_enable) begin
              state_s    = ST_BLANK;
              transfer_s = pending_r;
            end else begin
              state_s = ST_IDLE;
            end
          end else begin
            idx_s   = idx_r + IDX_ONE;
            state_s = ST_BLANK;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        idx_s   = '0;
        cnt_s   = '0;
      end
    endcase

    // Transfer needs pending=1 and acceptance needs pending=0, so they are exclusive.
    if (transfer_s) begin
      active_s  = shadow_r;
      pending_s = 1'b0;
    end else if (i_load && !pending_r) begin
      shadow_s  = i_digits;
      pending_s = 1'b1;
      bcd_err_s = any_invalid(i_digits);
    end else begin
      pending_s = pending_r;
    end

    cur_digit_s = digit_at(active_s, idx_s);
    abcd_s      = 4'd0;
    cs_s        = 1'b0;
    sel_s       = '0;
    case (state_s)
      ST_IDLE: begin
        abcd_s = 4'd0;
      end
      ST_BLANK: begin
        abcd_s = cur_digit_s;
      end
      ST_SHOW: begin
        abcd_s = cur_digit_s;
        cs_s   = (cur_digit_s <= 4'd9);
        for (int j = 0; j < NUM_DIGITS; j++) begin
          sel_s[j] = (idx_s == IW'(j));
        end
      end
      default: begin
        abcd_s = 4'd0;
      end
    endcase
  end

  // State, buffers and registered outputs; synchronous reset discards everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r      <= ST_IDLE;
      idx_r        <= '0;
      cnt_r        <= '0;
      shadow_r     <= '0;
      active_r     <= '0;
      pending_r    <= 1'b0;
      bcd_err_r    <= 1'b0;
      frame_done_r <= 1'b0;
      ready_r      <= 1'b1;
      abcd_r       <= 4'd0;
      cs_r         <= 1'b0;
      n_cs_r       <= 1'b1;
      sel_r        <= '0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      cnt_r        <= cnt_s;
      shadow_r     <= shadow_s;
      active_r     <= active_s;
      pending_r    <= pending_s;
      bcd_err_r    <= bcd_err_s;
      frame_done_r <= frame_done_s;
      ready_r      <= ~pending_s;
      abcd_r       <= abcd_s;
      cs_r         <= cs_s;
      n_cs_r       <= ~cs_s;
      sel_r        <= sel_s;
    end
  end

  assign o_ready      = ready_r;
  assign o_a          = abcd_r[0];
  assign o_b          = abcd_r[1];
  assign o_c          = abcd_r[2];
  assign o_d          = abcd_r[3];
  assign o_cs         = cs_r;
  assign o_n_cs_0     = n_cs_r;
  assign o_n_cs_1     = n_cs_r;
  assign o_digit_sel  = sel_r;
  assign o_frame_done = frame_done_r;
  assign o_bcd_err    = bcd_err_r;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// tb_bcd_scan_ctrl: directed checks of the scan controller at default
// parameters (4 digits, 2 blank + 16 dwell cycles, 72-cycle frame).
module tb_bcd_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        load;
  logic [15:0] digits;
  logic        ready, a, b, c_o, d_o, cs, n_cs_0, n_cs_1, frame_done, bcd_err;
  logic [3:0]  digit_sel;

  int total;
  int bad;

  // Observation vector: {ready, bcd_err, frame_done, sel[3:0], cs, n_cs_1, n_cs_0, d, c, b, a}
  logic [13:0] obs;
  assign obs = {ready, bcd_err, frame_done, digit_sel, cs, n_cs_1, n_cs_0, d_o, c_o, b, a};

  localparam logic [13:0] RST_V = 14'b1_0_0_0000_0_1_1_0000;

  bcd_scan_ctrl #(.NUM_DIGITS(4), .DWELL_CYCLES(16), .BLANK_CYCLES(2)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_enable     (enable),
    .i_load       (load),
    .i_digits     (digits),
    .o_ready      (ready),
    .o_a          (a),
    .o_b          (b),
    .o_c          (c_o),
    .o_d          (d_o),
    .o_cs         (cs),
    .o_n_cs_0     (n_cs_0),
    .o_n_cs_1     (n_cs_1),
    .o_digit_sel  (digit_sel),
    .o_frame_done (frame_done),
    .o_bcd_err    (bcd_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs for cycle c of a frame showing digit vector fr.
  function automatic logic [13:0] frame_exp(input int c, input logic [15:0] fr,
                                            input logic e_ready, input logic e_err,
                                            input logic e_fd);
    int         d;
    int         p;
    logic [3:0] dig;
    logic       cs_e;
    logic [3:0] sel_e;
    d     = c / 18;
    p     = c % 18;
    dig   = fr[4*d +: 4];
    cs_e  = (p >= 2) && (dig <= 4'd9);
    sel_e = (p >= 2) ? (4'b0001 << d) : 4'b0000;
    return {e_ready, e_err, e_fd, sel_e, cs_e, ~cs_e, ~cs_e, dig};
  endfunction

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; load = 1'b0; digits = 16'h0000;
    step(); step(); step();
    total++;
    if (obs !== RST_V) begin
      bad++; $display("FAIL reset_hold got=%b want=%b", obs, RST_V);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if (obs !== RST_V) begin
        bad++; $display("FAIL reset_idle i=%0d got=%b want=%b", i, obs, RST_V);
      end
    end
  endtask

  task automatic test_basic_scan();
    logic [13:0] exp;
    digits = {4'd3, 4'd1, 4'd4, 4'd1};
    load = 1'b1;
    step();
    load = 1'b0;
    exp = 14'b0_0_0_0000_0_1_1_0000;
    total++;
    if (obs !== exp) begin
      bad++; $display("FAIL idle_accept got=%b want=%b", obs, exp);
    end
    step();
    total++;
    if (obs !== RST_V) begin
      bad++; $display("FAIL idle_transfer got=%b want=%b", obs, RST_V);
    end
    enable = 1'b1;
    step();
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 72; c++) begin
        exp = frame_exp(c, {4'd3, 4'd1, 4'd4, 4'd1}, 1'b1, 1'b0, (f > 0) && (c == 0));
        total++;
        if (obs !== exp) begin
          bad++; $display("FAIL basic_scan f=%0d c=%0d got=%b want=%b", f, c, obs, exp);
        end
        step();
      end
    end
  endtask

  task automatic test_frame_atomic();
    logic [13:0] exp;
    logic [15:0] fr;
    logic        e_ready;
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 72; c++) begin
        fr      = (f == 0) ? {4'd3, 4'd1, 4'd4, 4'd1} : {4'd9, 4'd8, 4'd7, 4'd6};
        e_ready = !((f == 0) && (c >= 6));
        exp     = frame_exp(c, fr, e_ready, 1'b0, c == 0);
        total++;
        if (obs !== exp) begin
          bad++; $display("FAIL frame_atomic f=%0d c=%0d got=%b want=%b", f, c, obs, exp);
        end
        if (f == 0 && c == 5) begin
          digits = {4'd9, 4'd8, 4'd7, 4'd6}; load = 1'b1;
        end else if (f == 0 && c == 20) begin
          digits = 16'hFFFF; load = 1'b1;
        end else begin
          load = 1'b0;
        end
        step();
      end
    end
  endtask

  task automatic test_invalid_bcd();
    logic [13:0] exp;
    logic [15:0] fr;
    logic        e_ready;
    logic        e_err;
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 72; c++) begin
        fr      = (f == 0) ? {4'd9, 4'd8, 4'd7, 4'd6} : {4'd0, 4'd0, 4'hC, 4'd5};
        e_ready = (f == 0) ? (c == 0) : (c < 11);
        e_err   = (f == 0) ? (c >= 1) : (c < 11);
        exp     = frame_exp(c, fr, e_ready, e_err, c == 0);
        total++;
        if (obs !== exp) begin
          bad++; $display("FAIL invalid_bcd f=%0d c=%0d got=%b want=%b", f, c, obs, exp);
        end
        if (f == 0 && c == 0) begin
          digits = {4'd0, 4'd0, 4'hC, 4'd5}; load = 1'b1;
        end else if (f == 1 && c == 10) begin
          digits = {4'd0, 4'd0, 4'd0, 4'd1}; load = 1'b1;
        end else begin
          load = 1'b0;
        end
        step();
      end
    end
  endtask

  task automatic test_enable_drop();
    logic [13:0] exp;
    for (int c = 0; c < 72; c++) begin
      exp = frame_exp(c, {4'd0, 4'd0, 4'd0, 4'd1}, 1'b1, 1'b0, c == 0);
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL enable_drop c=%0d got=%b want=%b", c, obs, exp);
      end
      if (c == 10) begin
        enable = 1'b0;
      end else begin
        enable = enable;
      end
      step();
    end
    exp = 14'b1_0_1_0000_0_1_1_0000;
    total++;
    if (obs !== exp) begin
      bad++; $display("FAIL enable_drop_idle_done got=%b want=%b", obs, exp);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (obs !== RST_V) begin
        bad++; $display("FAIL enable_drop_idle i=%0d got=%b want=%b", i, obs, RST_V);
      end
    end
  endtask

  task automatic test_reset_mid_show();
    logic [13:0] exp;
    enable = 1'b1;
    step();
    for (int c = 0; c < 5; c++) begin
      step();
    end
    digits = {4'd9, 4'd9, 4'd9, 4'd9};
    load = 1'b1;
    step();
    load = 1'b0;
    exp = 14'b0_0_0_0001_1_0_0_0001;
    total++;
    if (obs !== exp) begin
      bad++; $display("FAIL mid_show_pending got=%b want=%b", obs, exp);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    enable = 1'b0;
    total++;
    if (obs !== RST_V) begin
      bad++; $display("FAIL mid_show_reset got=%b want=%b", obs, RST_V);
    end
    step();
    total++;
    if (obs !== RST_V) begin
      bad++; $display("FAIL post_reset_idle got=%b want=%b", obs, RST_V);
    end
    enable = 1'b1;
    step();
    for (int c = 0; c < 72; c++) begin
      exp = frame_exp(c, 16'h0000, 1'b1, 1'b0, 1'b0);
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL zeros_after_reset c=%0d got=%b want=%b", c, obs, exp);
      end
      step();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; enable = 1'b0; load = 1'b0; digits = 16'h0000;
    test_reset();
    test_basic_scan();
    test_frame_atomic();
    test_invalid_bcd();
    test_enable_drop();
    test_reset_mid_show();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
